// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_e;

    localparam logic [3:0] BLANK_CODE      = 4'd15;
    localparam int         DIGITS          = 4;
    localparam int         DEFAULT_MAX_VAL = 9999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a client and bin2bcd_seq; signal names match the display driver.
interface bin2bcd_seq_if #(
    parameter int BIN_W = 14
);

    logic             START;
    logic [BIN_W-1:0] BIN;
    logic             BUSY;
    logic             DONE;
    logic             OVF;
    logic [3:0]       BCD3;
    logic [3:0]       BCD2;
    logic [3:0]       BCD1;
    logic [3:0]       BCD0;

    modport master (
        output START, BIN,
        input  BUSY, DONE, OVF, BCD3, BCD2, BCD1, BCD0
    );

    modport slave (
        input  START, BIN,
        output BUSY, DONE, OVF, BCD3, BCD2, BCD1, BCD0
    );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (BCD0 is never blanked).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic               clk,
    input  logic               rst,
    bin2bcd_seq_if.slave       bus
);

    localparam int                CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIN_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit          LZB_EN  = 1'b1;
    localparam logic [15:0] BCD_RST = {BLANK_CODE, BLANK_CODE, BLANK_CODE, 4'd0};
`else
    localparam bit          LZB_EN  = 1'b0;
    localparam logic [15:0] BCD_RST = 16'h0000;
`endif

    state_e             state_q,    state_d;
    logic [BIN_W-1:0]   shift_q,    shift_d;
    logic [15:0]        scratch_q,  scratch_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               ovf_next_q, ovf_next_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               ovf_q,      ovf_d;
    logic [15:0]        bcd_q,      bcd_d;

    logic [15:0]        scratch_adj;
    logic [15:0]        load_bcd;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (scratch_q[4*g +: 4]),
            .nib_o (scratch_adj[4*g +: 4])
        );
    end

    // Final digits presented at LOAD: out-of-range blanks everything, else optional leading-zero blanking.
    always_comb begin
        load_bcd = scratch_q;
        if (ovf_next_q) begin
            load_bcd = {DIGITS{BLANK_CODE}};
        end else if (LZB_EN && scratch_q[15:12] == 4'd0) begin
            load_bcd[15:12] = BLANK_CODE;
            if (scratch_q[11:8] == 4'd0) begin
                load_bcd[11:8] = BLANK_CODE;
                if (scratch_q[7:4] == 4'd0) begin
                    load_bcd[7:4] = BLANK_CODE;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_next_d = ovf_next_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    shift_d    = bus.BIN;
                    scratch_d  = '0;
                    count_d    = '0;
                    ovf_next_d = (32'(bus.BIN) > 32'(MAX_VAL));
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // Carries out of the 16-bit scratch are dropped; such inputs are blanked via OVF.
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                count_d              = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = load_bcd;
                ovf_d   = ovf_next_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= BCD_RST;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_next_q <= ovf_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.OVF  = ovf_q;
    assign bus.BCD3 = bcd_q[15:12];
    assign bus.BCD2 = bcd_q[11:8];
    assign bus.BCD1 = bcd_q[7:4];
    assign bus.BCD0 = bcd_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq; expectations follow LEADING_ZERO_BLANK_EN when defined.
module tb_bin2bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [15:0] RST_BCD = LZB ? 16'hFFF0 : 16'h0000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bin2bcd_seq_if #(.BIN_W(14)) bus ();

    bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_now();
        return {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
    endfunction

    task automatic start_conv(input logic [13:0] v);
        bus.START = 1'b1;
        bus.BIN   = v;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bcd_now() !== RST_BCD) begin
            failures++;
            $display("[TB] FAIL reset_bcd: got %h expected %h", bcd_now(), RST_BCD);
        end
        checks++;
        if ({bus.BUSY, bus.DONE, bus.OVF} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {bus.BUSY, bus.DONE, bus.OVF});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.BUSY, bus.DONE} !== 2'b00 || bcd_now() !== RST_BCD) begin
            failures++;
            $display("[TB] FAIL idle_stable: got busy/done %b bcd %h expected 00 %h",
                     {bus.BUSY, bus.DONE}, bcd_now(), RST_BCD);
        end
    endtask

    task automatic test_basic();
        int done_k = -1;
        int n_done = 0;
        start_conv(14'd1234);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_busy_e0: got %b expected 1", bus.BUSY);
        end
        bus.BIN = 14'd4321;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin
                checks++;
                if (bcd_now() !== RST_BCD) begin
                    failures++;
                    $display("[TB] FAIL basic_hold: got %h expected %h", bcd_now(), RST_BCD);
                end
            end
            if (k == 14) begin
                checks++;
                if (bus.BUSY !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL basic_busy_last: got %b expected 1", bus.BUSY);
                end
            end
            if (k == 15) begin
                checks++;
                if (bus.BUSY !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL basic_busy_drop: got %b expected 0", bus.BUSY);
                end
            end
            if (bus.DONE) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
        checks++;
        if (done_k !== 15) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d expected 15", done_k);
        end
        checks++;
        if (n_done !== 1) begin
            failures++;
            $display("[TB] FAIL basic_done_count: got %0d expected 1", n_done);
        end
        checks++;
        if (bcd_now() !== 16'h1234 || bus.OVF !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_value: got %h ovf %b expected 1234 ovf 0", bcd_now(), bus.OVF);
        end
    endtask

    task automatic test_boundaries();
        logic [13:0] vin   [8] = '{14'd0, 14'd7, 14'd42, 14'd305, 14'd1005, 14'd9999, 14'd10000, 14'd16383};
        logic [15:0] plain [8] = '{16'h0000, 16'h0007, 16'h0042, 16'h0305, 16'h1005, 16'h9999, 16'hFFFF, 16'hFFFF};
        logic [15:0] blank [8] = '{16'hFFF0, 16'hFFF7, 16'hFF42, 16'hF305, 16'h1005, 16'h9999, 16'hFFFF, 16'hFFFF};
        logic        ovf   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        logic [15:0] exp_bcd;
        for (int i = 0; i < 8; i++) begin
            exp_bcd = LZB ? blank[i] : plain[i];
            start_conv(vin[i]);
            wait_done(lat);
            checks++;
            if (lat !== 15) begin
                failures++;
                $display("[TB] FAIL bound_latency[%0d]: got %0d expected 15", vin[i], lat);
            end
            checks++;
            if (bcd_now() !== exp_bcd || bus.OVF !== ovf[i]) begin
                failures++;
                $display("[TB] FAIL bound_value[%0d]: got %h ovf %b expected %h ovf %b",
                         vin[i], bcd_now(), bus.OVF, exp_bcd, ovf[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int lat;
        start_conv(14'd4444);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.OVF} !== 3'b000 || bcd_now() !== RST_BCD) begin
            failures++;
            $display("[TB] FAIL midreset_state: got flags %b bcd %h expected 000 %h",
                     {bus.BUSY, bus.DONE, bus.OVF}, bcd_now(), RST_BCD);
        end
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done: got %0d expected 0", n_done);
        end
        start_conv(14'd42);
        wait_done(lat);
        checks++;
        if (lat !== 15 || bcd_now() !== (LZB ? 16'hFF42 : 16'h0042)) begin
            failures++;
            $display("[TB] FAIL midreset_recover: got lat %0d bcd %h expected 15 %h",
                     lat, bcd_now(), LZB ? 16'hFF42 : 16'h0042);
        end
    endtask

    task automatic test_start_ignored();
        int done_k = -1;
        int n_done = 0;
        start_conv(14'd1111);
        bus.BIN = 14'd2222;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.START = (k == 2 || k == 9);
            if (bus.DONE) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
        bus.START = 1'b0;
        checks++;
        if (n_done !== 1 || done_k !== 15) begin
            failures++;
            $display("[TB] FAIL ignore_done: got count %0d at %0d expected 1 at 15", n_done, done_k);
        end
        checks++;
        if (bcd_now() !== 16'h1111) begin
            failures++;
            $display("[TB] FAIL ignore_value: got %h expected 1111", bcd_now());
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] exp1 = LZB ? 16'hF567 : 16'h0567;
        logic [15:0] exp2 = LZB ? 16'hFFF8 : 16'h0008;
        start_conv(14'd567);
        wait_done(lat);
        checks++;
        if (lat !== 15 || bcd_now() !== exp1) begin
            failures++;
            $display("[TB] FAIL b2b_first: got lat %0d bcd %h expected 15 %h", lat, bcd_now(), exp1);
        end
        start_conv(14'd8);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got busy %b expected 1", bus.BUSY);
        end
        wait_done(lat);
        checks++;
        if (lat !== 15 || bcd_now() !== exp2) begin
            failures++;
            $display("[TB] FAIL b2b_second: got lat %0d bcd %h expected 15 %h", lat, bcd_now(), exp2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_done_width: got %b expected 0", bus.DONE);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.BIN   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
